// File: rtl/tmds_pkg.sv
// Shared TMDS definitions for the transmit and receive paths.
package tmds_pkg;

  localparam int unsigned SYM_W  = 10;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CTRL_W = 2;
  localparam int unsigned OFF_W  = 4;

  localparam logic [SYM_W-1:0] CTL_TOKEN_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] CTL_TOKEN_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] CTL_TOKEN_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] CTL_TOKEN_11 = 10'b1010101011;
  localparam logic [SYM_W-1:0] CLK_PATTERN  = 10'b0000011111;

  typedef enum logic {SEARCH, LOCKED} link_state_t;

  typedef struct packed {
    logic              is_ctl;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } sym_dec_t;

  function automatic logic is_ctl_token(input logic [SYM_W-1:0] sym);
    return (sym == CTL_TOKEN_00) || (sym == CTL_TOKEN_01) ||
           (sym == CTL_TOKEN_10) || (sym == CTL_TOKEN_11);
  endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational 10b symbol decode to control token value or 8b pixel byte.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [SYM_W-1:0] sym,
  output sym_dec_t         dec_c
);

  logic [DATA_W-1:0] t;

  always_comb begin
    dec_c = '0;
    t     = sym[9] ? ~sym[7:0] : sym[7:0];
    dec_c.data[0] = t[0];
    for (int i = 1; i < int'(DATA_W); i++) begin
      dec_c.data[i] = sym[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
    end
    case (sym)
      CTL_TOKEN_00: begin dec_c.is_ctl = 1'b1; dec_c.ctrl = 2'b00; end
      CTL_TOKEN_01: begin dec_c.is_ctl = 1'b1; dec_c.ctrl = 2'b01; end
      CTL_TOKEN_10: begin dec_c.is_ctl = 1'b1; dec_c.ctrl = 2'b10; end
      CTL_TOKEN_11: begin dec_c.is_ctl = 1'b1; dec_c.ctrl = 2'b11; end
      default:      ;
    endcase
  end

endmodule

// File: rtl/tmds_rx_decoder.sv
// TMDS receive channel: symbol alignment via control-token runs, then 10b->8b decode.
module tmds_rx_decoder
  import tmds_pkg::*;
#(
  parameter int unsigned LOCK_RUN       = 8,
  parameter int unsigned SEARCH_TIMEOUT = 2048,
  parameter int unsigned LOSS_TIMEOUT   = 2048,
  parameter int unsigned CNT_W          = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SYM_W-1:0]  raw_in,
  output logic              blank,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data,
  output logic              locked,
  output logic [OFF_W-1:0]  offset
);

  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(LOCK_RUN - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(SEARCH_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOSS_LAST = CNT_W'(LOSS_TIMEOUT - 1);
  localparam logic [OFF_W-1:0] OFF_LAST  = OFF_W'(SYM_W - 1);

  link_state_t         state;
  logic [SYM_W-1:0]    raw_prev;
  logic [SYM_W-1:0]    aligned;
  logic [SYM_W-1:0]    sym_q;
  logic [2*SYM_W-1:0]  window;
  logic                is_ctl;
  logic                ctl_q;
  logic [CNT_W-1:0]    run_cnt;
  logic [CNT_W-1:0]    tmo_cnt;
  logic [CNT_W-1:0]    loss_cnt;
  logic [OFF_W-1:0]    offset_next;
  sym_dec_t            dec;

  // Bit 0 of raw_prev is the earliest bit in the two-word window.
  assign window      = {raw_in, raw_prev};
  assign aligned     = window[5'(offset) +: SYM_W];
  assign is_ctl      = is_ctl_token(aligned);
  assign offset_next = (offset == OFF_LAST) ? '0 : offset + OFF_W'(1);

  tmds_symbol_decode u_decode (
    .sym   (sym_q),
    .dec_c (dec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SEARCH;
      offset   <= '0;
      run_cnt  <= '0;
      tmo_cnt  <= '0;
      loss_cnt <= '0;
      raw_prev <= '0;
      sym_q    <= '0;
      ctl_q    <= 1'b0;
      blank    <= 1'b1;
      ctrl     <= '0;
      data     <= '0;
      locked   <= 1'b0;
    end else begin
      raw_prev <= raw_in;
      sym_q    <= aligned;
      ctl_q    <= is_ctl;

      // Output stage; ctrl is left untouched across pixel data.
      if (!locked) begin
        blank <= 1'b1;
        ctrl  <= '0;
        data  <= '0;
      end else if (ctl_q && dec.is_ctl) begin
        blank <= 1'b1;
        ctrl  <= dec.ctrl;
        data  <= '0;
      end else begin
        blank <= 1'b0;
        data  <= dec.data;
      end

      case (state)
        SEARCH: begin
          if (is_ctl && (run_cnt == RUN_LAST)) begin
            state   <= LOCKED;
            locked  <= 1'b1;
            run_cnt <= '0;
            tmo_cnt <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            offset  <= offset_next;
            run_cnt <= '0;
            tmo_cnt <= '0;
          end else begin
            run_cnt <= is_ctl ? run_cnt + CNT_W'(1) : '0;
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        LOCKED: begin
          if (is_ctl) begin
            loss_cnt <= '0;
          end else if (loss_cnt == LOSS_LAST) begin
            state    <= SEARCH;
            locked   <= 1'b0;
            loss_cnt <= '0;
            run_cnt  <= '0;
            tmo_cnt  <= '0;
            offset   <= offset_next;
          end else begin
            loss_cnt <= loss_cnt + CNT_W'(1);
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_tmds_rx_decoder.sv
// Bench for tmds_rx_decoder: symbol-stream generator with bit skew and a behavioural channel model.
module tb_tmds_rx_decoder;

  localparam int LOCK_RUN       = 8;
  localparam int SEARCH_TIMEOUT = 2048;
  localparam int LOSS_TIMEOUT   = 2048;

  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK01 = 10'b0010101011;
  localparam logic [9:0] TOK10 = 10'b0101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] raw_in = '0;
  logic       blank;
  logic [1:0] ctrl;
  logic [7:0] data;
  logic       locked;
  logic [3:0] offset;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model of the channel as seen at the outputs.
  logic [9:0] m_prev = '0;
  logic [9:0] m_sym  = '0;
  bit         m_locked = 0;
  int         m_off = 0, m_run = 0, m_tmo = 0, m_loss = 0;
  bit         m_blank = 1;
  logic [1:0] m_ctrl = '0;
  logic [7:0] m_data = '0;

  // Transmit-side symbol stream, delivered with 'skew' bits of misalignment.
  logic [9:0] s_prev = '0;
  int         skew = 0;

  tmds_rx_decoder dut (
    .clk    (clk),
    .reset  (reset),
    .raw_in (raw_in),
    .blank  (blank),
    .ctrl   (ctrl),
    .data   (data),
    .locked (locked),
    .offset (offset)
  );

  always #5 clk = ~clk;

  function automatic int tok_val(input logic [9:0] s);
    if (s == TOK00) return 0;
    if (s == TOK01) return 1;
    if (s == TOK10) return 2;
    if (s == TOK11) return 3;
    return -1;
  endfunction

  function automatic logic [7:0] decode8(input logic [9:0] q);
    logic [7:0] t, d;
    t = q[9] ? ~q[7:0] : q[7:0];
    d[0] = t[0];
    for (int i = 1; i < 8; i++) d[i] = q[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
    return d;
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] s;
    s = 10'($urandom);
    while (tok_val(s) >= 0) s = 10'($urandom);
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, advance the model across the edge, compare all outputs.
  task automatic step(input logic [9:0] raw, input bit rst);
    logic [19:0] w;
    logic [9:0]  al;
    int          tv, sv;
    raw_in = raw;
    reset  = rst;
    w  = {raw, m_prev};
    al = 10'(w >> m_off);
    tv = tok_val(al);
    sv = tok_val(m_sym);
    @(posedge clk);
    if (rst) begin
      m_prev = '0; m_sym = '0; m_locked = 0;
      m_off = 0; m_run = 0; m_tmo = 0; m_loss = 0;
      m_blank = 1; m_ctrl = '0; m_data = '0;
    end else begin
      if (!m_locked) begin
        m_blank = 1; m_ctrl = '0; m_data = '0;
      end else if (sv >= 0) begin
        m_blank = 1; m_ctrl = 2'(sv); m_data = '0;
      end else begin
        m_blank = 0; m_data = decode8(m_sym);
      end
      if (!m_locked) begin
        if (tv >= 0 && m_run == LOCK_RUN - 1) begin
          m_locked = 1; m_run = 0; m_tmo = 0;
        end else if (m_tmo == SEARCH_TIMEOUT - 1) begin
          m_off = (m_off + 1) % 10; m_run = 0; m_tmo = 0;
        end else begin
          m_run = (tv >= 0) ? m_run + 1 : 0;
          m_tmo++;
        end
      end else begin
        if (tv >= 0) m_loss = 0;
        else if (m_loss == LOSS_TIMEOUT - 1) begin
          m_locked = 0; m_loss = 0; m_run = 0; m_tmo = 0; m_off = (m_off + 1) % 10;
        end else m_loss++;
      end
      m_sym  = al;
      m_prev = raw;
    end
    #1;
    chk("blank",  32'(blank),  32'(m_blank));
    chk("ctrl",   32'(ctrl),   32'(m_ctrl));
    chk("data",   32'(data),   32'(m_data));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("offset", 32'(offset), 32'(m_off));
  endtask

  task automatic send(input logic [9:0] s);
    logic [19:0] w;
    w = {s, s_prev};
    s_prev = s;
    step(10'(w >> (10 - skew)), 1'b0);
  endtask

  task automatic do_reset();
    step('0, 1'b1);
    step('0, 1'b1);
    s_prev = '0;
  endtask

  initial begin
    logic [9:0] toks [4];
    toks[0] = TOK00; toks[1] = TOK01; toks[2] = TOK10; toks[3] = TOK11;

    // Reset values
    do_reset();
    chk("rst_blank", 32'(blank), 32'd1);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_offset", 32'(offset), 32'd0);

    // Lock at true offset 0: first aligned word is the reset raw_prev
    skew = 0;
    for (int i = 1; i <= 9; i++) begin
      send(TOK00);
      if (i == 8) chk("t1_not_yet_locked", 32'(locked), 32'd0);
    end
    chk("t1_locked", 32'(locked), 32'd1);
    for (int i = 0; i < 3; i++) send(TOK00);
    chk("t1_blank", 32'(blank), 32'd1);
    chk("t1_ctrl", 32'(ctrl), 32'd0);
    chk("t1_offset", 32'(offset), 32'd0);

    // Data latency through blanking of token 10
    for (int i = 0; i < 4; i++) send(TOK10);
    send(10'b0100000000);
    chk("t3_lat0", 32'(blank), 32'd1);
    send(10'b1011111111);
    chk("t3_lat1", 32'(blank), 32'd1);
    send(TOK10);
    chk("t3_d0_blank", 32'(blank), 32'd0);
    chk("t3_d0", 32'(data), 32'h00);
    chk("t3_ctrl_hold", 32'(ctrl), 32'd2);
    send(TOK10);
    chk("t3_d1_blank", 32'(blank), 32'd0);
    chk("t3_d1", 32'(data), 32'hFE);
    send(TOK10);
    chk("t3_back_blank", 32'(blank), 32'd1);
    chk("t3_back_ctrl", 32'(ctrl), 32'd2);

    // Random lines: token bursts and short data runs while locked
    for (int l = 0; l < 40; l++) begin
      int tk = int'($urandom_range(3, 0));
      for (int i = 0; i < int'($urandom_range(6, 1)); i++) send(toks[tk]);
      for (int i = 0; i < int'($urandom_range(12, 1)); i++) send(rand_data());
    end
    send(TOK00);
    chk("rand_still_locked", 32'(locked), 32'd1);

    // Loss of lock after a long stretch without tokens
    for (int i = 1; i <= LOSS_TIMEOUT + 2; i++) begin
      send(rand_data());
      if (i == LOSS_TIMEOUT) chk("t4_still_locked", 32'(locked), 32'd1);
      if (i == LOSS_TIMEOUT + 1) begin
        chk("t4_unlocked", 32'(locked), 32'd0);
        chk("t4_offset", 32'(offset), 32'd1);
      end
      if (i == LOSS_TIMEOUT + 2) chk("t4_blank", 32'(blank), 32'd1);
    end

    // Search across offsets with a 3-bit skewed token stream
    do_reset();
    skew = 3;
    for (int i = 1; i <= 3 * SEARCH_TIMEOUT + LOCK_RUN; i++) begin
      send(TOK00);
      if (i == SEARCH_TIMEOUT)     chk("t2_off1", 32'(offset), 32'd1);
      if (i == 2 * SEARCH_TIMEOUT) chk("t2_off2", 32'(offset), 32'd2);
      if (i == 3 * SEARCH_TIMEOUT) chk("t2_off3", 32'(offset), 32'd3);
      if (i == 3 * SEARCH_TIMEOUT + LOCK_RUN - 1) chk("t2_pre_lock", 32'(locked), 32'd0);
    end
    chk("t2_locked", 32'(locked), 32'd1);
    for (int i = 0; i < 4; i++) send(TOK01);
    chk("t2_ctrl", 32'(ctrl), 32'd1);
    chk("t2_offset", 32'(offset), 32'd3);

    // Reset asserted mid-line while locked
    for (int i = 0; i < 5; i++) send(rand_data());
    step(10'($urandom), 1'b1);
    chk("t6_locked", 32'(locked), 32'd0);
    chk("t6_blank", 32'(blank), 32'd1);
    chk("t6_ctrl", 32'(ctrl), 32'd0);
    chk("t6_data", 32'(data), 32'd0);
    chk("t6_offset", 32'(offset), 32'd0);

    // A broken run must restart the lock count
    do_reset();
    skew = 0;
    for (int i = 0; i < 7; i++) send(TOK11);
    send(rand_data());
    chk("t5_break", 32'(locked), 32'd0);
    for (int i = 1; i <= 9; i++) begin
      send(TOK11);
      if (i == 8) chk("t5_not_yet", 32'(locked), 32'd0);
    end
    chk("t5_locked", 32'(locked), 32'd1);
    for (int i = 0; i < 3; i++) send(TOK11);
    chk("t5_ctrl", 32'(ctrl), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
